// File: rtl/user_ship_renderer_pkg.sv
// Shared screen, colour and sprite constants for the player ship renderer.
package user_ship_renderer_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int SHIP_SIZE = 8;

  localparam logic [6:0] SHIP_Y      = 7'd112;
  localparam logic [2:0] SHIP_COLOUR = 3'b111;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

endpackage

// File: rtl/user_ship_renderer_sprite_rom.sv
// Combinational 8x8 ship sprite mask; bit 7 is the leftmost pixel of a row.
module ship_sprite_rom (
  input  logic [2:0] i_row,
  output logic [7:0] o_mask
);

  always_comb begin
    o_mask = 8'b0000_0000;
    case (i_row)
      3'd0: o_mask = 8'b0001_1000;
      3'd1: o_mask = 8'b0011_1100;
      3'd2: o_mask = 8'b0011_1100;
      3'd3: o_mask = 8'b0111_1110;
      3'd4: o_mask = 8'b1111_1111;
      3'd5: o_mask = 8'b1111_1111;
      3'd6: o_mask = 8'b1101_1011;
      3'd7: o_mask = 8'b1000_0001;
      default: o_mask = 8'b0000_0000;
    endcase
  end

endmodule

// File: rtl/user_ship_renderer.sv
// Erases the ship at its old x and redraws it at the new x through a plot/ready
// pixel port whenever the movement handler's x position changes.
module user_ship_renderer
  import user_ship_renderer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] x_val,
  input  logic       plot_ready,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ERASE,
    S_DRAW
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_drawn_x, w_drawn_nxt;
  logic [7:0] r_target_x, w_target_nxt;
  logic [2:0] r_row, w_row_nxt;
  logic [2:0] r_col, w_col_nxt;
  logic       r_done, w_done_nxt;

  logic [7:0] w_mask;
  logic [7:0] w_base;
  logic [8:0] w_sum;
  logic       w_active;
  logic       w_visible;
  logic       w_plot;
  logic       w_adv;
  logic       w_last;

  ship_sprite_rom u_rom (
    .i_row  (r_row),
    .o_mask (w_mask)
  );

  // Pixel decode uses registers and the ROM only, so plot/ready never loops back.
  always_comb begin
    w_active  = (r_state == S_ERASE) || (r_state == S_DRAW);
    w_base    = (r_state == S_ERASE) ? r_drawn_x : r_target_x;
    w_sum     = {1'b0, w_base} + {6'b0, r_col};
    w_visible = (w_sum < 9'(SCREEN_W)) &&
                ((r_state != S_DRAW) || w_mask[3'd7 - r_col]);
    w_plot    = w_active && w_visible;
    w_adv     = w_active && (!w_plot || plot_ready);
    w_last    = (r_row == 3'(SHIP_SIZE - 1)) && (r_col == 3'(SHIP_SIZE - 1));
  end

  assign plot       = w_plot;
  assign vga_x      = w_active ? w_sum[7:0] : 8'd0;
  assign vga_y      = w_active ? (SHIP_Y + {4'b0, r_row}) : 7'd0;
  assign vga_colour = (r_state == S_DRAW) ? SHIP_COLOUR : BG_COLOUR;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_drawn_x  <= 8'd0;
      r_target_x <= 8'd0;
      r_row      <= 3'd0;
      r_col      <= 3'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_drawn_x  <= w_drawn_nxt;
      r_target_x <= w_target_nxt;
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drawn_nxt  = r_drawn_x;
    w_target_nxt = r_target_x;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_done_nxt   = 1'b0;

    case (r_state)
      // Screen is cleared elsewhere at game start, so the first draw skips erase.
      S_INIT: begin
        w_target_nxt = x_val;
        w_row_nxt    = 3'd0;
        w_col_nxt    = 3'd0;
        w_state_nxt  = S_DRAW;
      end
      S_IDLE: begin
        if (x_val != r_drawn_x) begin
          w_target_nxt = x_val;
          w_row_nxt    = 3'd0;
          w_col_nxt    = 3'd0;
          w_state_nxt  = S_ERASE;
        end
      end
      S_ERASE, S_DRAW: begin
        if (w_adv) begin
          if (w_last) begin
            w_row_nxt = 3'd0;
            w_col_nxt = 3'd0;
            if (r_state == S_ERASE) begin
              w_state_nxt = S_DRAW;
            end else begin
              w_drawn_nxt = r_target_x;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_col_nxt = r_col + 3'd1;
            if (r_col == 3'd7) w_row_nxt = r_row + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

endmodule
